// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES round datapath (forward and inverse column
// mappers, multi-cycle column engines).
//   COL_W / BYTE_W : column and byte widths of the AES state
//   GF_RED         : low byte of the AES field polynomial 0x11B
//   state_t        : control states of the column-serial engines
//   xtime()        : multiply a field element by x (i.e. by 02)
// -----------------------------------------------------------------------------
package aes_pkg;

  localparam int COL_W  = 32;
  localparam int BYTE_W = 8;

  localparam logic [BYTE_W-1:0] GF_RED = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Shift left by one bit and fold the overflowing x^8 term back into the
  // field using the reduction constant.
  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] a);
    return {a[BYTE_W-2:0], 1'b0} ^ (a[BYTE_W-1] ? GF_RED : 8'h00);
  endfunction

endpackage

// File: rtl/invmapcolumn.sv
// -----------------------------------------------------------------------------
// invmapcolumn
// Purely combinational AES InvMixColumns mapping of a single 32-bit column.
//   col_in  : input column, byte s0 in bits [31:24] down to s3 in [7:0]
//   col_out : mapped column, same byte layout
// Each byte is multiplied by 09/0b/0d/0e using a shared xtime chain
// (x2, x4, x8) so only three xtime stages are built per byte.
// -----------------------------------------------------------------------------
module invmapcolumn
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] col_in,
  output logic [COL_W-1:0] col_out
);

  logic [3:0][BYTE_W-1:0] s;
  logic [3:0][BYTE_W-1:0] x2;
  logic [3:0][BYTE_W-1:0] x4;
  logic [3:0][BYTE_W-1:0] x8;
  logic [3:0][BYTE_W-1:0] m09;
  logic [3:0][BYTE_W-1:0] m0b;
  logic [3:0][BYTE_W-1:0] m0d;
  logic [3:0][BYTE_W-1:0] m0e;

  // Index 0 is s0, the most significant byte of the column.
  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign s[i]   = col_in[COL_W-1-BYTE_W*i -: BYTE_W];
    assign x2[i]  = xtime(s[i]);
    assign x4[i]  = xtime(x2[i]);
    assign x8[i]  = xtime(x4[i]);
    assign m09[i] = x8[i] ^ s[i];
    assign m0b[i] = x8[i] ^ x2[i] ^ s[i];
    assign m0d[i] = x8[i] ^ x4[i] ^ s[i];
    assign m0e[i] = x8[i] ^ x4[i] ^ x2[i];
  end

  // Circulant inverse matrix rows: 0e 0b 0d 09, rotated right per row.
  assign col_out = {
    m0e[0] ^ m0b[1] ^ m0d[2] ^ m09[3],
    m09[0] ^ m0e[1] ^ m0b[2] ^ m0d[3],
    m0d[0] ^ m09[1] ^ m0e[2] ^ m0b[3],
    m0b[0] ^ m0d[1] ^ m09[2] ^ m0e[3]
  };

endmodule

// File: rtl/invmixcolumns.sv
// -----------------------------------------------------------------------------
// invmixcolumns
// Column-serial AES InvMixColumns stage: one 128-bit state is captured, then
// its four columns are pushed through a single shared invmapcolumn, one per
// cycle, and the result is held until the downstream side takes it.
//   clk     : clock, all state changes on the rising edge
//   rst     : synchronous reset, active low
//   i_data  : input state, column c in bits [127-32c -: 32], s0 = MSB
//   i_valid : i_data valid
//   o_ready : block can accept (combinational from state and i_ready)
//   o_data  : transformed state, same layout as i_data
//   o_valid : o_data valid
//   i_ready : downstream accepts o_data
// Latency is four cycles from the accept edge to o_valid; in DONE a new
// block can be accepted in the same cycle the finished one leaves.
// -----------------------------------------------------------------------------
module invmixcolumns
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] i_data,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [127:0] o_data,
  output logic         o_valid,
  input  logic         i_ready
);

  state_t             state;
  state_t             next_state;
  logic [1:0]         col;
  logic [127:0]       cap;
  logic [COL_W-1:0]   col_sel;
  logic [COL_W-1:0]   col_map;
  logic               accept;
  logic               out_xfer;

  assign accept   = i_valid && o_ready;
  assign out_xfer = o_valid && i_ready;

  // Select the captured column currently being worked on.
  always_comb begin
    col_sel = cap[127:96];
    case (col)
      2'd0: col_sel = cap[127:96];
      2'd1: col_sel = cap[95:64];
      2'd2: col_sel = cap[63:32];
      2'd3: col_sel = cap[31:0];
      default: col_sel = cap[127:96];
    endcase
  end

  invmapcolumn u_map (
    .col_in  (col_sel),
    .col_out (col_map)
  );

  // In DONE, readiness follows i_ready so that an output transfer and a new
  // input transfer can share one edge; otherwise i_valid is ignored there.
  always_comb begin
    next_state = state;
    o_ready    = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) next_state = CALC;
      end
      CALC: begin
        if (col == 2'd3) next_state = DONE;
      end
      DONE: begin
        o_ready = i_ready;
        if (i_ready) next_state = i_valid ? CALC : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Capture and accept never coincide with CALC, so the counter has a single
  // writer per cycle; the 2-bit counter wraps to 0 on the last column.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      col     <= 2'd0;
      cap     <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        cap <= i_data;
        col <= 2'd0;
      end
      if (state == CALC) begin
        case (col)
          2'd0: o_data[127:96] <= col_map;
          2'd1: o_data[95:64]  <= col_map;
          2'd2: o_data[63:32]  <= col_map;
          2'd3: o_data[31:0]   <= col_map;
          default: o_data[127:96] <= col_map;
        endcase
        col <= col + 2'd1;
      end
      if (state == CALC && col == 2'd3) begin
        o_valid <= 1'b1;
      end else if (out_xfer) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_invmixcolumns.sv
// -----------------------------------------------------------------------------
// tb_invmixcolumns
// Self-checking bench for invmixcolumns. Expected states are queued when a
// block is accepted and compared when the block leaves the DUT. Expected
// values come from constant vectors or from a forward MixColumns model: a
// random state is forward-mixed, fed in, and must come back unchanged.
// -----------------------------------------------------------------------------
module tb_invmixcolumns;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] i_data = '0;
  logic         i_valid = 1'b0;
  logic         i_ready = 1'b1;
  logic         o_ready;
  logic [127:0] o_data;
  logic         o_valid;

  int           tot = 0;
  int           bad = 0;
  int           cyc = 0;
  int           accEdge = 0;
  logic         prevValid = 1'b0;
  logic [127:0] expCur = '0;
  logic [127:0] sb[$];

  typedef struct {
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  invmixcolumns dut (
    .clk     (clk),
    .rst     (rst),
    .i_data  (i_data),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_valid (o_valid),
    .i_ready (i_ready)
  );

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    tot++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
  endfunction

  // Forward MixColumns of one column: rows 02 03 01 01, rotated.
  function automatic logic [31:0] fwdCol(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  function automatic logic [127:0] fwdState(input logic [127:0] s);
    return {fwdCol(s[127:96]), fwdCol(s[95:64]), fwdCol(s[63:32]), fwdCol(s[31:0])};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Transfers are decided at the negedge before the edge that performs them,
  // since inputs only change just after a rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
      prevValid = 1'b0;
    end else begin
      if (o_valid && !prevValid) begin
        checkOutput("latency", 128'(cyc - accEdge), 128'd4);
      end
      if (o_valid && i_ready) begin
        if (sb.size() == 0) begin
          tot++;
          bad++;
          $display("[TB] FAIL unexpected_output: got %h expected none", o_data);
        end else begin
          checkOutput("block", o_data, sb.pop_front());
        end
      end
      if (i_valid && o_ready) begin
        sb.push_back(expCur);
        accEdge = cyc + 1;
      end
      prevValid = o_valid;
    end
  end

  // Offer one block and return just after its accept edge. With scramble set
  // the input bus is overwritten with garbage for two cycles afterwards.
  task automatic applyStimulus(input logic [127:0] din, input logic [127:0] exp,
                               input bit hold, input bit scramble, output int accAt);
    i_data  = din;
    expCur  = exp;
    i_valid = 1'b1;
    accAt   = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (o_ready) begin
        accAt = cyc + 1;
        break;
      end
    end
    if (accAt < 0) begin
      tot++;
      bad++;
      $display("[TB] FAIL accept_timeout: got no accept expected accept within 60 cycles");
      i_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      if (!hold) i_valid = 1'b0;
      if (scramble) begin
        i_data = rnd128();
        repeat (2) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic waitDrain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !o_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      tot++;
      bad++;
      $display("[TB] FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int a;
    int acc[3];
    logic [127:0] orig;
    logic [127:0] din;
    bit seen;

    vecs[0] = '{128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 128'hdb135345_f20a225c_01010101_c6c6c6c6};
    vecs[1] = '{128'hd5d5d7d6_00000000_00000000_00000000, 128'hd4d4d4d5_00000000_00000000_00000000};
    vecs[2] = '{128'h00000000_00000000_4d7ebdf8_00000000, 128'h00000000_00000000_2d26314c_00000000};
    vecs[3] = '{128'h00000000_00000000_00000000_00000000, 128'h00000000_00000000_00000000_00000000};
    vecs[4] = '{128'h00000000_4d7ebdf8_00000000_d5d5d7d6, 128'h00000000_2d26314c_00000000_d4d4d4d5};

    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_valid", 128'(o_valid), 128'd0);
    checkOutput("rst_data", o_data, 128'd0);
    checkOutput("rst_ready", 128'(o_ready), 128'd1);
    @(posedge clk);
    #1;

    // Known-answer vectors
    i_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].din, vecs[i].exp, 1'b0, 1'b0, a);
      waitDrain();
    end

    // Backpressure: result must sit still and a pending input must wait
    i_ready = 1'b0;
    applyStimulus(vecs[0].din, vecs[0].exp, 1'b0, 1'b0, a);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_valid) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("bp_valid_seen", 128'(seen), 128'd1);
    @(posedge clk);
    #1;
    i_data  = vecs[1].din;
    expCur  = vecs[1].exp;
    i_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput("bp_data", o_data, vecs[0].exp);
      checkOutput("bp_valid", 128'(o_valid), 128'd1);
      checkOutput("bp_ready", 128'(o_ready), 128'd0);
    end
    checkOutput("bp_pending", 128'(sb.size()), 128'd1);
    @(posedge clk);
    #1 i_ready = 1'b1;
    @(posedge clk);
    #1 i_valid = 1'b0;
    waitDrain();

    // Back-to-back blocks with the input bus scrambled after each accept
    i_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      orig = rnd128();
      din  = fwdState(orig);
      applyStimulus(din, orig, 1'b1, 1'b1, acc[j]);
    end
    i_valid = 1'b0;
    checkOutput("b2b_gap01", 128'(acc[1] - acc[0]), 128'd5);
    checkOutput("b2b_gap12", 128'(acc[2] - acc[1]), 128'd5);
    waitDrain();

    // Reset in CALC with col == 2
    applyStimulus(vecs[0].din, vecs[0].exp, 1'b0, 1'b0, a);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_valid", 128'(o_valid), 128'd0);
    checkOutput("mid_rst_data", o_data, 128'd0);
    checkOutput("mid_rst_ready", 128'(o_ready), 128'd1);
    @(posedge clk);
    #1;
    applyStimulus(vecs[2].din, vecs[2].exp, 1'b0, 1'b0, a);
    waitDrain();

    // Round trip through the forward model
    for (int n = 0; n < 1000; n++) begin
      orig = rnd128();
      applyStimulus(fwdState(orig), orig, 1'b0, 1'b0, a);
    end
    waitDrain();

    checkOutput("sb_empty", 128'(sb.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
